// File: rtl/ofifo_deskew.sv
`default_nettype none
// ============================================================================
// Module   : ofifo_deskew
// Brief    : Output column buffer bank. Lanes are filled independently (skewed)
//            and drained one full aligned row per accepted read.
//            Optional sticky error flag: define OFIFO_DESKEW_ERR_EN.
// Revision : 1.0 - initial release
// ============================================================================
module ofifo_deskew #(
  parameter int col   = 8,
  parameter int bw    = 16,
  parameter int DEPTH = 64
) (
  input  logic                clk,
  input  logic                reset,
  input  logic [col-1:0]      wr,
  input  logic [col*bw-1:0]   in,
  input  logic                rd,
  output logic [col*bw-1:0]   out,
  output logic                o_valid,
  output logic                o_full
`ifdef OFIFO_DESKEW_ERR_EN
  ,
  output logic                o_err
`endif
);

  localparam int AW = $clog2(DEPTH);

  logic [col-1:0] w_empty;
  logic [col-1:0] w_full;
  logic [col-1:0] w_wr_acc;
  logic           w_rd_acc;

  assign o_valid  = &(~w_empty);
  assign o_full   = |w_full;
  assign w_rd_acc = rd & o_valid;

  for (genvar i = 0; i < col; i++) begin : g_lane
    logic [AW:0]   r_wr_ptr;
    logic [AW:0]   r_rd_ptr;
    logic [bw-1:0] r_mem [DEPTH];
    logic [bw-1:0] r_out;

    assign w_empty[i] = (r_wr_ptr == r_rd_ptr);
    assign w_full[i]  = (r_wr_ptr[AW] != r_rd_ptr[AW]) &&
                        (r_wr_ptr[AW-1:0] == r_rd_ptr[AW-1:0]);
    // A full lane still takes a write when the row read frees its head slot.
    assign w_wr_acc[i] = wr[i] & (~w_full[i] | w_rd_acc);

    always_ff @(posedge clk) begin
      if (reset) begin
        r_wr_ptr <= '0;
        r_rd_ptr <= '0;
      end else begin
        if (w_wr_acc[i]) r_wr_ptr <= r_wr_ptr + 1'b1;
        if (w_rd_acc)    r_rd_ptr <= r_rd_ptr + 1'b1;
      end
    end

    always_ff @(posedge clk) begin
      if (w_wr_acc[i]) r_mem[r_wr_ptr[AW-1:0]] <= in[bw*i +: bw];
    end

    always_ff @(posedge clk) begin
      if (reset)         r_out <= '0;
      else if (w_rd_acc) r_out <= r_mem[r_rd_ptr[AW-1:0]];
    end

    assign out[bw*i +: bw] = r_out;
  end

`ifdef OFIFO_DESKEW_ERR_EN
  logic r_err;
  always_ff @(posedge clk) begin
    if (reset) begin
      r_err <= 1'b0;
    end else if ((|(wr & w_full & ~{col{w_rd_acc}})) || (rd && !o_valid)) begin
      r_err <= 1'b1;
    end
  end
  assign o_err = r_err;
`endif

endmodule
`default_nettype wire
